// File: rtl/csa32_wide_seq.sv
// csa32_wide_seq: drives an external combinational carry-select adder one word per cycle,
// least-significant word first, chaining the carry, and returns the NWORDS*WIDTH-bit sum on a
// valid/ready handshake. Define CSA32_WIDE_SEQ_OVF_EN to add the signed-overflow output out_ovf.
module csa32_wide_seq #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NWORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NWORDS*WIDTH-1:0]  in_a,
   input  logic [NWORDS*WIDTH-1:0]  in_b,
   input  logic                     in_cin,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   output logic                     add_cin,
   input  logic [WIDTH-1:0]         add_sum,
   input  logic                     add_cout,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NWORDS*WIDTH-1:0]  out_sum,
   output logic                     out_cout
`ifdef CSA32_WIDE_SEQ_OVF_EN
   ,
   output logic                     out_ovf
`endif
);

   localparam int unsigned IdxW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
   typedef logic [NWORDS-1:0][WIDTH-1:0] wide_t;

   state_e          state_q, state_d;
   wide_t           a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic            carry_q, carry_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [IdxW-1:0] sel;

`ifdef CSA32_WIDE_SEQ_OVF_EN
   logic            ovf_q, ovf_d;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: one RUN cycle per word, then hold the result until taken.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid)          state_d = StRun;
         StRun:   if (idx_q == LastIdx)  state_d = StDone;
         StDone:  if (out_ready)         state_d = StIdle;
         default:                        state_d = StIdle;
      endcase
   end

   // Datapath registers: operands, collected sum words, chained carry, word index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
`ifdef CSA32_WIDE_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
`ifdef CSA32_WIDE_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Datapath next-state: latch on accept, capture one adder word per RUN cycle.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      idx_d   = idx_q;
`ifdef CSA32_WIDE_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               idx_d   = '0;
            end
         end
         StRun: begin
            sum_d[idx_q] = add_sum;
            carry_d      = add_cout;
            // Index saturates at the last word so it never wraps.
            if (idx_q != LastIdx) begin
               idx_d = idx_q + IdxW'(1);
            end
`ifdef CSA32_WIDE_SEQ_OVF_EN
            if (idx_q == LastIdx) begin
               ovf_d = (a_q[NWORDS-1][WIDTH-1] == b_q[NWORDS-1][WIDTH-1]) &&
                       (add_sum[WIDTH-1] != a_q[NWORDS-1][WIDTH-1]);
            end
`endif
         end
         default: ;
      endcase
   end

   // Outputs: adder fed from the current word in RUN, word 0 otherwise.
   always_comb begin
      sel       = (state_q == StRun) ? idx_q : '0;
      add_a     = a_q[sel];
      add_b     = b_q[sel];
      add_cin   = carry_q;
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
      out_sum   = sum_q;
      out_cout  = carry_q;
`ifdef CSA32_WIDE_SEQ_OVF_EN
      out_ovf   = ovf_q;
`endif
   end

endmodule

// File: tb/tb_csa32_wide_seq.sv
// Bench for csa32_wide_seq: behavioural adder model on the add_* side, scoreboard of expected
// wide sums pushed at acceptance and popped when out_valid is seen.
module tb_csa32_wide_seq;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned NWORDS = 4;
   localparam int unsigned TW     = WIDTH * NWORDS;

   typedef logic [TW:0] cw_t;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [TW-1:0]     in_a;
   logic [TW-1:0]     in_b;
   logic              in_cin;
   logic [WIDTH-1:0]  add_a;
   logic [WIDTH-1:0]  add_b;
   logic              add_cin;
   logic [WIDTH-1:0]  add_sum;
   logic              add_cout;
   logic              out_valid;
   logic              out_ready;
   logic [TW-1:0]     out_sum;
   logic              out_cout;
`ifdef CSA32_WIDE_SEQ_OVF_EN
   logic              out_ovf;
`endif

   logic [WIDTH:0]    add_res;
   logic [TW+1:0]     sb_q[$];
   int                n_cmp;
   int                n_err;

   csa32_wide_seq #(
      .WIDTH  (WIDTH),
      .NWORDS (NWORDS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
`ifdef CSA32_WIDE_SEQ_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   // Stand-in for the external combinational adder.
   assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
   assign add_sum  = add_res[WIDTH-1:0];
   assign add_cout = add_res[WIDTH];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input cw_t obs, input cw_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One job: offer, count latency, compare against scoreboard, optional back-pressure, drain.
   task automatic run_job(input string tag, input logic [TW-1:0] a, input logic [TW-1:0] b,
                          input logic cin, input int bp);
      cw_t           full;
      logic          ovf;
      logic [TW+1:0] exp;
      int            lat;
      full = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin};
      ovf  = (a[TW-1] == b[TW-1]) && (full[TW-1] != a[TW-1]);
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, cw_t'(in_ready), cw_t'(1));
      @(posedge clk);
      sb_q.push_back({ovf, full});
      @(negedge clk);
      // Scramble the inputs to show the operands were latched.
      in_valid = 1'b0;
      in_a     = ~a;
      in_b     = ~b;
      in_cin   = ~cin;
      lat      = 0;
      while (out_valid !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, cw_t'(lat), cw_t'(NWORDS));
      chk({tag, "_sb_depth"}, cw_t'(sb_q.size()), cw_t'(1));
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
      chk({tag, "_sum"}, cw_t'(out_sum), cw_t'(exp[TW-1:0]));
      chk({tag, "_cout"}, cw_t'(out_cout), cw_t'(exp[TW]));
`ifdef CSA32_WIDE_SEQ_OVF_EN
      chk({tag, "_ovf"}, cw_t'(out_ovf), cw_t'(exp[TW+1]));
`endif
      for (int i = 0; i < bp; i++) begin
         in_valid = 1'b1;
         in_a     = {TW{1'b1}};
         in_b     = {TW{1'b1}};
         @(negedge clk);
         chk({tag, "_bp_valid"}, cw_t'(out_valid), cw_t'(1));
         chk({tag, "_bp_sum"}, cw_t'(out_sum), cw_t'(exp[TW-1:0]));
         chk({tag, "_bp_cout"}, cw_t'(out_cout), cw_t'(exp[TW]));
         chk({tag, "_bp_in_ready"}, cw_t'(in_ready), cw_t'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_drain_valid"}, cw_t'(out_valid), cw_t'(0));
      chk({tag, "_drain_in_ready"}, cw_t'(in_ready), cw_t'(1));
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b0;

      // Reset state.
      #12;
      chk("rst_in_ready", cw_t'(in_ready), cw_t'(1));
      chk("rst_out_valid", cw_t'(out_valid), cw_t'(0));
      chk("rst_out_sum", cw_t'(out_sum), cw_t'(0));
      chk("rst_out_cout", cw_t'(out_cout), cw_t'(0));
      chk("rst_add_a", cw_t'(add_a), cw_t'(0));
      chk("rst_add_cin", cw_t'(add_cin), cw_t'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Carry across two word boundaries.
      run_job("t1", 128'hFFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 0);
      // Carry ripples through every word.
      run_job("t2", {TW{1'b1}}, '0, 1'b1, 0);
      // Small decimal operands, both carry-in values.
      run_job("t3a", 128'd80231, 128'd4234950, 1'b0, 0);
      run_job("t3b", 128'd80231, 128'd4234950, 1'b1, 0);
      // Back-pressure for 5 cycles with a competing request offered.
      run_job("t4", 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
              128'hF0F0_F0F0_0F0F_0F0F_AAAA_5555_FFFF_0001, 1'b1, 5);
      run_job("t4_next", 128'd7, 128'd9, 1'b0, 0);

      // Reset during RUN at word index 2.
      @(negedge clk);
      in_a     = 128'hDEAD_BEEF_0000_0001_FFFF_FFFF_1234_5678;
      in_b     = 128'h0000_0001_8000_0000_0000_0001_8765_4321;
      in_cin   = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_out_valid", cw_t'(out_valid), cw_t'(0));
      chk("t5_rst_in_ready", cw_t'(in_ready), cw_t'(1));
      chk("t5_rst_out_sum", cw_t'(out_sum), cw_t'(0));
      chk("t5_rst_out_cout", cw_t'(out_cout), cw_t'(0));
      chk("t5_rst_add_a", cw_t'(add_a), cw_t'(0));
      chk("t5_rst_add_b", cw_t'(add_b), cw_t'(0));
      chk("t5_rst_add_cin", cw_t'(add_cin), cw_t'(0));
`ifdef CSA32_WIDE_SEQ_OVF_EN
      chk("t5_rst_ovf", cw_t'(out_ovf), cw_t'(0));
`endif
      @(negedge clk);
      rst_n = 1'b1;
      run_job("t5_after", 128'd100000000, 128'd13, 1'b0, 0);

      // Signed overflow corner cases (out_ovf checked when the feature is built).
      run_job("t6a", {1'b0, {(TW-1){1'b1}}}, 128'd1, 1'b0, 0);
      run_job("t6b", {TW{1'b1}}, 128'd1, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
